dmem_responder: RTL and testbench

Data-memory responder for the single-issue RISC-V core. It serves the load and store requests raised by the decoded mem_load / do_store control lines: it accepts one request per handshake, models a configurable wait-state latency, performs byte, half or word access per funct3, and returns sign- or zero-extended load data. It sits between the core datapath and on-chip data RAM. Its busy output stalls the pipeline.

---
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder.sv | 196 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core datapath and the data-memory responder.
// master = core side, slave = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req_valid, req_load, req_store,
    output funct3, addr, wdata,
    input  req_ready, rsp_valid, rdata, err, busy
  );

  modport slave (
    input  req_valid, req_load, req_store,
    input  funct3, addr, wdata,
    output req_ready, rsp_valid, rdata, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, fixed wait states,
// byte/half/word lanes with sign or zero extension on loads.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam logic [3:0] LAT  = 4'(LATENCY);
  localparam int         AW   = ADDR_WIDTH + 2;
  localparam int         DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] ram [0:DEPTH-1];

  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;
  logic [2:0]    l_f3;
  logic          l_store;
  logic          l_err;

  logic          accept;
  logic          enter_resp;
  logic          in_err;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  logic [2:0]    e_f3;
  logic          e_store;
  logic          e_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   wd;
  logic [3:0]    be;
  logic          wr_en;
  logic [31:0]   rsp_data;
  logic          unused_hi;

  assign unused_hi = ^bus.addr[31:AW];

  function automatic logic bad_req(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic e;
    e = (ld == st);
    unique case (f3)
      3'b000:  e = e;
      3'b001:  e = e | a[0];
      3'b010:  e = e | (a != 2'b00);
      3'b100:  e = e | st;
      3'b101:  e = e | st | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  a
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign accept = (state == IDLE) && bus.req_valid;
  assign in_err = bad_req(bus.req_load, bus.req_store,
                          bus.funct3, bus.addr[1:0]);

  // With zero latency RESP is entered on the accept edge, so the
  // access must be taken straight from the bus instead of the latches.
  always_comb begin
    e_addr  = l_addr;
    e_wdata = l_wdata;
    e_f3    = l_f3;
    e_store = l_store;
    e_err   = l_err;
    if (state == IDLE) begin
      e_addr  = bus.addr[AW-1:0];
      e_wdata = bus.wdata;
      e_f3    = bus.funct3;
      e_store = bus.req_store;
      e_err   = in_err;
    end
  end

  assign enter_resp = (accept && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == LAT));

  assign idx  = e_addr[AW-1:2];
  assign word = ram[idx];

  always_comb begin
    wd = e_wdata;
    be = 4'b1111;
    unique case (e_f3[1:0])
      2'b00: begin
        wd = {4{e_wdata[7:0]}};
        be = 4'b0001 << e_addr[1:0];
      end
      2'b01: begin
        wd = {2{e_wdata[15:0]}};
        be = e_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wd = e_wdata;
        be = 4'b1111;
      end
    endcase
  end

  assign wr_en    = enter_resp && e_store && !e_err;
  assign rsp_data = (e_store || e_err) ? 32'h0 :
                    ld_ext(word, e_f3, e_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.err       <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (accept) begin
        l_addr  <= bus.addr[AW-1:0];
        l_wdata <= bus.wdata;
        l_f3    <= bus.funct3;
        l_store <= bus.req_store;
        l_err   <= in_err;
      end
      if (enter_resp) begin
        bus.rsp_valid <= 1'b1;
        bus.rdata     <= rsp_data;
        bus.err       <= e_err;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt           <= 4'd0;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT) state <= RESP;
          else            cnt   <= cnt + 4'd1;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
          bus.rdata     <= 32'h0;
          bus.err       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table through a response scoreboard,
// plus hand sequences for held requests, reset in WAIT and zero latency.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if b0 ();

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic        eerr;
    int          acc;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want 0");
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", bus.rdata, mon_e.exp);
        chk("err", {31'h0, bus.err}, {31'h0, mon_e.eerr});
        chk("latency", 32'(cyc - mon_e.acc), 32'(LAT + 1));
      end
    end
  end

  task automatic issue(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got %b want 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_load  = v.ld;
    bus.req_store = v.st;
    bus.funct3    = v.f3;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    sb.push_back('{v.exp, v.eerr, cyc + 1});
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.addr      = 32'hFFFF_FFFF;
    bus.wdata     = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st,
                              input logic [2:0] f3,
                              input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [31:0] ex,
                              input logic ee);
    vec_t v;
    v = '{ld, st, f3, a, wd, ex, ee};
    return v;
  endfunction

  initial begin
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    b0.req_valid  = 1'b0;
    b0.req_load   = 1'b0;
    b0.req_store  = 1'b0;
    b0.funct3     = 3'b000;
    b0.addr       = 32'h0;
    b0.wdata      = 32'h0;

    tv.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    tv.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    tv.push_back(mk(0, 1, 3'b000, 32'h11, 32'h80, 32'h0, 0));
    tv.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0));
    tv.push_back(mk(1, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0));
    tv.push_back(mk(1, 0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0));
    tv.push_back(mk(1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0));
    tv.push_back(mk(1, 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0));
    tv.push_back(mk(1, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1));
    tv.push_back(mk(0, 1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1));
    tv.push_back(mk(0, 1, 3'b100, 32'h10, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 1, 3'b010, 32'h10, 32'h0, 32'h0, 1));
    tv.push_back(mk(0, 0, 3'b010, 32'h10, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0));
    tv.push_back(mk(1, 0, 3'b010, 32'h1010, 32'h0, 32'hDEAD80EF, 0));
    tv.push_back(mk(0, 1, 3'b001, 32'h12, 32'h12345678, 32'h0, 0));
    tv.push_back(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'h567880EF, 0));
    tv.push_back(mk(1, 0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      issue(tv[i]);
      drain();
    end

    // request held through WAIT with a conflicting store must be dropped
    @(negedge clk);
    chk("hold_ready0", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1;
    bus.req_load  = 1'b1;
    bus.req_store = 1'b0;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h10;
    sb.push_back('{32'h567880EF, 1'b0, cyc + 1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.req_load  = 1'b0;
        bus.req_store = 1'b1;
        bus.addr      = 32'h14;
        bus.wdata     = 32'hAAAAAAAA;
        bus.addr      = 32'h10;
      end
      chk("hold_ready", {31'h0, bus.req_ready}, 32'h0);
      chk("hold_busy", {31'h0, bus.busy}, 32'h1);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
    issue(mk(1, 0, 3'b010, 32'h10, 32'h0, 32'h567880EF, 0));
    drain();

    // reset landing on the RESP entry edge of a store
    issue(mk(0, 1, 3'b010, 32'h20, 32'h11112222, 32'h0, 0));
    drain();
    @(negedge clk);
    chk("rst_seq_ready", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b1;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h20;
    bus.wdata     = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_wait_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_wait_ready", {31'h0, bus.req_ready}, 32'h1);
    issue(mk(1, 0, 3'b010, 32'h20, 32'h0, 32'h11112222, 0));
    drain();

    // zero-latency build
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_load  = 1'b0;
    b0.req_store = 1'b1;
    b0.funct3    = 3'b010;
    b0.addr      = 32'h30;
    b0.wdata     = 32'hCAFEF00D;
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("l0_st_rsp", {31'h0, b0.rsp_valid}, 32'h1);
    chk("l0_st_err", {31'h0, b0.err}, 32'h0);
    chk("l0_st_busy", {31'h0, b0.busy}, 32'h1);
    @(negedge clk);
    chk("l0_idle_rsp", {31'h0, b0.rsp_valid}, 32'h0);
    chk("l0_idle_ready", {31'h0, b0.req_ready}, 32'h1);
    b0.req_valid = 1'b1;
    b0.req_load  = 1'b1;
    b0.req_store = 1'b0;
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("l0_ld_rsp", {31'h0, b0.rsp_valid}, 32'h1);
    chk("l0_ld_rdata", b0.rdata, 32'hCAFEF00D);
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.funct3    = 3'b001;
    b0.addr      = 32'h31;
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("l0_err_rsp", {31'h0, b0.rsp_valid}, 32'h1);
    chk("l0_err", {31'h0, b0.err}, 32'h1);
    chk("l0_err_rdata", b0.rdata, 32'h0);

    repeat (6) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
